conversor_bin_bcd_seq: RTL

CONVERSOR_BIN_BCD_SEQ -- requirements
Module: conversor_bin_bcd_seq

---
 rtl/conversor_bin_bcd_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/conversor_bin_bcd_seq.sv
// conversor_bin_bcd_seq: sequential binary-to-BCD converter (shift-add-3).
// One bit per clock; fixed latency of LARGURA+1 edges from start to Pronto.
// Optional build macro CONVERSOR_BCD_SINAL_EN: Entrada is taken as two's
// complement, the magnitude is converted and the sign is reported on Negativo.
// Without the macro Entrada is unsigned and Negativo stays 0.
module conversor_bin_bcd_seq #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Inicio,
  input  logic [LARGURA-1:0]     Entrada,
  output logic [4*DIGITOS-1:0]   Saida,
  output logic                   Ocupado,
  output logic                   Pronto,
  output logic                   Estouro,
  output logic                   Negativo
);

  localparam int BW = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] CARGA = CW'(LARGURA);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  estado_t              estado_r;
  logic [CW-1:0]        contador_r;
  logic [LARGURA-1:0]   desloc_r;
  logic [BW-1:0]        acum_r;
  logic                 estouro_acum_r;

  logic [BW-1:0]        corrigido_s;
  logic [BW-1:0]        acum_prox_s;
  logic [LARGURA-1:0]   desloc_prox_s;
  logic                 estouro_passo_s;
  logic [LARGURA-1:0]   operando_s;

`ifdef CONVERSOR_BCD_SINAL_EN
  logic                 sinal_s;
  logic                 sinal_r;
`endif

  // Shift-add-3 digit correction: digits of 5 or more get 3 added (no carry out).
  function automatic logic [3:0] corrige_digito(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Operand selection at start: raw value, or magnitude when signed mode is built.
  always_comb begin
`ifdef CONVERSOR_BCD_SINAL_EN
    sinal_s    = Entrada[LARGURA-1];
    operando_s = sinal_s ? ((~Entrada) + LARGURA'(1)) : Entrada;
`else
    operando_s = Entrada;
`endif
  end

  // One conversion step: correct every digit, then shift {acc, shreg} left by one.
  always_comb begin
    corrigido_s = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      corrigido_s[4*i +: 4] = corrige_digito(acum_r[4*i +: 4]);
    end
    acum_prox_s     = {corrigido_s[BW-2:0], desloc_r[LARGURA-1]};
    desloc_prox_s   = {desloc_r[LARGURA-2:0], 1'b0};
    // A top-digit correction always reaches 8+, and a set top bit is lost in the shift.
    estouro_passo_s = (acum_r[BW-1 -: 4] >= 4'd5) | corrigido_s[BW-1];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      estado_r       <= OCIOSO;
      contador_r     <= '0;
      desloc_r       <= '0;
      acum_r         <= '0;
      estouro_acum_r <= 1'b0;
      Saida          <= '0;
      Ocupado        <= 1'b0;
      Pronto         <= 1'b0;
      Estouro        <= 1'b0;
      Negativo       <= 1'b0;
`ifdef CONVERSOR_BCD_SINAL_EN
      sinal_r        <= 1'b0;
`endif
    end else begin
      case (estado_r)
        OCIOSO: begin
          Pronto <= 1'b0;
          if (Inicio) begin
            desloc_r       <= operando_s;
            acum_r         <= '0;
            estouro_acum_r <= 1'b0;
            contador_r     <= CARGA;
            Ocupado        <= 1'b1;
            estado_r       <= CONVERTE;
`ifdef CONVERSOR_BCD_SINAL_EN
            sinal_r        <= sinal_s;
`endif
          end
        end
        CONVERTE: begin
          if (contador_r != {CW{1'b0}}) begin
            acum_r         <= acum_prox_s;
            desloc_r       <= desloc_prox_s;
            estouro_acum_r <= estouro_acum_r | estouro_passo_s;
            contador_r     <= contador_r - CW'(1);
            // Last shift: publish results on the same edge that enters FIM.
            if (contador_r == CW'(1)) begin
              Saida    <= acum_prox_s;
              Estouro  <= estouro_acum_r | estouro_passo_s;
`ifdef CONVERSOR_BCD_SINAL_EN
              Negativo <= sinal_r;
`else
              Negativo <= 1'b0;
`endif
              estado_r <= FIM;
            end
          end else begin
            estado_r <= FIM;
          end
        end
        FIM: begin
          Pronto   <= 1'b1;
          Ocupado  <= 1'b0;
          estado_r <= OCIOSO;
        end
        default: begin
          Pronto   <= 1'b0;
          Ocupado  <= 1'b0;
          estado_r <= OCIOSO;
        end
      endcase
    end
  end

endmodule
